// File: rtl/revive_fetch_align_if.sv
// Fetch/decode handshake bundle for revive_fetch_align.
//   master : the fetch unit and the decoder around the aligner. It drives the
//            beat, the redirect and instr_rdy.
//   slave  : the aligner. It drives the buffer-ready, instruction and level
//            outputs.
// Signals:
//   mem_data / mem_data_vld / mem_data_rdy : fetch beat handshake
//   flush / flush_hw_offset                : redirect and target halfword
//   instr_out / instr_is_32bit / instr_vld / instr_rdy : decode handshake
//   level                                  : halfwords currently buffered
interface revive_fetch_align_if #(
  parameter int W_DATA   = 32,
  parameter int DEPTH_HW = 6
);
  localparam int NHW = W_DATA / 16;
  localparam int SW  = $clog2(NHW);
  localparam int LW  = $clog2(DEPTH_HW) + 1;

  logic [W_DATA-1:0] mem_data;
  logic              mem_data_vld;
  logic              mem_data_rdy;
  logic              flush;
  logic [SW-1:0]     flush_hw_offset;
  logic [31:0]       instr_out;
  logic              instr_is_32bit;
  logic              instr_vld;
  logic              instr_rdy;
  logic [LW-1:0]     level;

  modport master (
    output mem_data, mem_data_vld, flush, flush_hw_offset, instr_rdy,
    input  mem_data_rdy, instr_out, instr_is_32bit, instr_vld, level
  );

  modport slave (
    input  mem_data, mem_data_vld, flush, flush_hw_offset, instr_rdy,
    output mem_data_rdy, instr_out, instr_is_32bit, instr_vld, level
  );
endinterface

// File: rtl/revive_fetch_align.sv
// Halfword-granular instruction prefetch and realignment buffer.
// Fetch beats are split into 16-bit halfwords and appended to a shift FIFO.
// The head halfword is decoded to decide between a 16-bit and a 32-bit
// instruction, and exactly one whole instruction is presented to decode.
// A 32-bit instruction that straddles two beats waits until both halves are
// buffered. A redirect can land on any halfword of the first beat after it.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : revive_fetch_align_if.slave (beat in, instruction out, level)
module revive_fetch_align #(
  parameter int W_DATA      = 32,
  parameter int DEPTH_HW    = 6,
  parameter int PASSTHROUGH = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  revive_fetch_align_if.slave   bus
);
  localparam int NHW = W_DATA / 16;
  localparam int SW  = $clog2(NHW);
  localparam int LW  = $clog2(DEPTH_HW) + 1;
  localparam bit PT  = (PASSTHROUGH != 0);

  // Buffer state; hw_reg[0] is the oldest halfword.
  logic [15:0]   hw_reg   [DEPTH_HW];
  logic [15:0]   hw_next  [DEPTH_HW];
  logic [LW-1:0] level_reg, level_next;
  logic [SW-1:0] skip_reg, skip_next;

  // Zero-padded views, so every shift/select below uses constant indices.
  logic [15:0]   hw_ext   [DEPTH_HW+2];
  logic [15:0]   beat_ext [2*NHW];
  logic [15:0]   shifted  [DEPTH_HW];
  logic [15:0]   push_hw  [NHW];

  logic          need_two;
  logic          instr_vld_w;
  logic          mem_data_rdy_w;
  logic          do_pop;
  logic          do_push;
  logic [LW-1:0] pop_n;
  logic [LW-1:0] push_n;
  logic [LW-1:0] keep;
  logic [SW-1:0] offset_eff;
  logic [31:0]   instr_out_w;

  generate
    for (genvar gi = 0; gi < DEPTH_HW; gi++) begin : g_hw_ext
      assign hw_ext[gi] = hw_reg[gi];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_hw_pad
      assign hw_ext[DEPTH_HW+gi] = 16'h0;
    end
    for (genvar gi = 0; gi < NHW; gi++) begin : g_beat_ext
      assign beat_ext[gi]     = bus.mem_data[16*gi +: 16];
      assign beat_ext[NHW+gi] = 16'h0;
    end
  endgenerate

  // Head decode: a 32-bit opcode (or any instruction when C is disabled)
  // needs two halfwords before it can be presented.
  assign need_two       = PT || (hw_reg[0][1:0] == 2'b11);
  assign instr_vld_w    = need_two ? (level_reg >= LW'(2)) : (level_reg != '0);
  // Beat acceptance looks only at the registered level, never at instr_rdy.
  assign mem_data_rdy_w = (level_reg <= LW'(DEPTH_HW - NHW));

  assign do_pop  = instr_vld_w && bus.instr_rdy;
  assign do_push = bus.mem_data_vld && mem_data_rdy_w;
  assign pop_n   = do_pop ? (need_two ? LW'(2) : LW'(1)) : '0;
  assign push_n  = do_push ? (LW'(NHW) - LW'(skip_reg)) : '0;
  assign keep    = level_reg - pop_n;

  // With C disabled every target is word aligned, so an odd offset is dropped.
  assign offset_eff = PT ? (bus.flush_hw_offset & ~SW'(1)) : bus.flush_hw_offset;

  generate
    // Surviving halfwords after the pop, moved down to the head.
    for (genvar gi = 0; gi < DEPTH_HW; gi++) begin : g_shift
      assign shifted[gi] = (pop_n == LW'(2)) ? hw_ext[gi+2] :
                           (pop_n == LW'(1)) ? hw_ext[gi+1] : hw_ext[gi];
    end

    // Beat halfwords starting at the skip position, packed to index 0.
    for (genvar gi = 0; gi < NHW; gi++) begin : g_push_sel
      logic [15:0] sel;
      always_comb begin
        sel = 16'h0;
        for (int s = 0; s < NHW; s++) begin
          if (skip_reg == SW'(s)) sel = beat_ext[gi+s];
        end
      end
      assign push_hw[gi] = sel;
    end

    // Each slot keeps a shifted survivor or receives the k-th pushed halfword.
    for (genvar gi = 0; gi < DEPTH_HW; gi++) begin : g_slot
      logic [15:0] val;
      always_comb begin
        val = 16'h0;
        if (LW'(gi) < keep) begin
          val = shifted[gi];
        end else begin
          for (int k = 0; k < NHW; k++) begin
            if ((LW'(gi) == keep + LW'(k)) && (LW'(k) < push_n)) val = push_hw[k];
          end
        end
      end
      assign hw_next[gi] = val;
    end
  endgenerate

  // A redirect discards everything, including a simultaneous push or pop.
  always_comb begin
    level_next = level_reg - pop_n + push_n;
    skip_next  = do_push ? '0 : skip_reg;
    if (bus.flush) begin
      level_next = '0;
      skip_next  = offset_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= '0;
      skip_reg  <= '0;
      for (int i = 0; i < DEPTH_HW; i++) hw_reg[i] <= 16'h0;
    end else begin
      level_reg <= level_next;
      skip_reg  <= skip_next;
      for (int i = 0; i < DEPTH_HW; i++) hw_reg[i] <= hw_next[i];
    end
  end

  always_comb begin
    instr_out_w = 32'h0;
    if (instr_vld_w) begin
      instr_out_w = need_two ? {hw_reg[1], hw_reg[0]} : {16'h0, hw_reg[0]};
      if (PT) instr_out_w[1:0] = 2'b11;
    end
  end

  assign bus.instr_out      = instr_out_w;
  assign bus.instr_vld      = instr_vld_w;
  assign bus.instr_is_32bit = instr_vld_w && need_two;
  assign bus.mem_data_rdy   = mem_data_rdy_w;
  assign bus.level          = level_reg;
endmodule
